// File: rtl/lgn_pkg.sv
// ---------------------------------------------------------------------------
// lgn_pkg
// Shared constants for the NAND-only reference gate set.
//   - Per-lane reset values of each output (the A=B=0 results), used when the
//     output register stage is compiled in.
//   - NAND cell counts per logic function and per lane.
// ---------------------------------------------------------------------------
package lgn_pkg;

    // Per-lane reset values (registered mode).
    localparam logic LGN_RST_AND  = 1'b0;
    localparam logic LGN_RST_OR   = 1'b0;
    localparam logic LGN_RST_NOT  = 1'b1;
    localparam logic LGN_RST_NOR  = 1'b1;
    localparam logic LGN_RST_XOR  = 1'b0;
    localparam logic LGN_RST_XNOR = 1'b1;

    // NAND cells used by each network, per lane.
    localparam int unsigned LGN_CELLS_NOT  = 32'd1;
    localparam int unsigned LGN_CELLS_AND  = 32'd2;
    localparam int unsigned LGN_CELLS_OR   = 32'd3;
    localparam int unsigned LGN_CELLS_NOR  = 32'd4;
    localparam int unsigned LGN_CELLS_XOR  = 32'd4;
    localparam int unsigned LGN_CELLS_XNOR = 32'd5;

    localparam int unsigned LGN_CELLS_PER_LANE = LGN_CELLS_NOT + LGN_CELLS_AND
                                               + LGN_CELLS_OR  + LGN_CELLS_NOR
                                               + LGN_CELLS_XOR + LGN_CELLS_XNOR;

endpackage

// File: rtl/logic_gates_using_nand_if.sv
// ---------------------------------------------------------------------------
// logic_gates_using_nand_if
// Operand and result bundle of the NAND-only gate set.
//   A, B               : operands (WIDTH bits, bitwise per lane)
//   and_out .. xnor_out: results (WIDTH bits each)
// Modports:
//   master - drives A/B, observes the results (stimulus side)
//   slave  - receives A/B, drives the results (gate set side)
// ---------------------------------------------------------------------------
interface logic_gates_using_nand_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] and_out;
    logic [WIDTH-1:0] or_out;
    logic [WIDTH-1:0] not_out;
    logic [WIDTH-1:0] nor_out;
    logic [WIDTH-1:0] xor_out;
    logic [WIDTH-1:0] xnor_out;

    modport master (
        output A, B,
        input  and_out, or_out, not_out, nor_out, xor_out, xnor_out
    );

    modport slave (
        input  A, B,
        output and_out, or_out, not_out, nor_out, xor_out, xnor_out
    );
endinterface

// File: rtl/nand2.sv
// ---------------------------------------------------------------------------
// nand2
// Single 2-input NAND cell, the only logic primitive of the gate set.
//   A, B : inputs (1 bit)
//   Y    : ~(A & B)
// ---------------------------------------------------------------------------
module nand2 (
    input  logic A,
    input  logic B,
    output logic Y
);
    assign Y = ~(A & B);
endmodule

// File: rtl/logic_gates_using_nand.sv
// ---------------------------------------------------------------------------
// logic_gates_using_nand
// Bitwise AND/OR/NOT/NOR/XOR/XNOR of A and B built only from nand2 cells,
// 19 cells per lane, lanes fully independent.
//   clk   : clock, used only with the output register stage
//   rst_n : asynchronous active-low reset, used only with the output register
//   bus   : logic_gates_using_nand_if.slave (A, B in; six results out)
// Build option:
//   LOGIC_GATES_USING_NAND_REG_OUT_EN defined   -> results registered on the
//       rising clk edge (1-cycle latency), reset to the A=B=0 values.
//   LOGIC_GATES_USING_NAND_REG_OUT_EN undefined -> purely combinational.
// ---------------------------------------------------------------------------
module logic_gates_using_nand
    import lgn_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    logic_gates_using_nand_if.slave       bus
);

    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] or_s;
    logic [WIDTH-1:0] not_s;
    logic [WIDTH-1:0] nor_s;
    logic [WIDTH-1:0] xor_s;
    logic [WIDTH-1:0] xnor_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic a_s;
        logic b_s;
        logic [18:0] c_s;

        assign a_s = bus.A[i];
        assign b_s = bus.B[i];

        // NOT
        nand2 u_c0  (.A(a_s),     .B(a_s),     .Y(c_s[0]));
        // AND
        nand2 u_c1  (.A(a_s),     .B(b_s),     .Y(c_s[1]));
        nand2 u_c2  (.A(c_s[1]),  .B(c_s[1]),  .Y(c_s[2]));
        // OR: De Morgan on the inverted operands
        nand2 u_c3  (.A(a_s),     .B(a_s),     .Y(c_s[3]));
        nand2 u_c4  (.A(b_s),     .B(b_s),     .Y(c_s[4]));
        nand2 u_c5  (.A(c_s[3]),  .B(c_s[4]),  .Y(c_s[5]));
        // NOR: its own OR network followed by an inverter cell
        nand2 u_c6  (.A(a_s),     .B(a_s),     .Y(c_s[6]));
        nand2 u_c7  (.A(b_s),     .B(b_s),     .Y(c_s[7]));
        nand2 u_c8  (.A(c_s[6]),  .B(c_s[7]),  .Y(c_s[8]));
        nand2 u_c9  (.A(c_s[8]),  .B(c_s[8]),  .Y(c_s[9]));
        // XOR: classic 4-cell form sharing x = nand(A,B)
        nand2 u_c10 (.A(a_s),     .B(b_s),     .Y(c_s[10]));
        nand2 u_c11 (.A(a_s),     .B(c_s[10]), .Y(c_s[11]));
        nand2 u_c12 (.A(b_s),     .B(c_s[10]), .Y(c_s[12]));
        nand2 u_c13 (.A(c_s[11]), .B(c_s[12]), .Y(c_s[13]));
        // XNOR: its own XOR network followed by an inverter cell
        nand2 u_c14 (.A(a_s),     .B(b_s),     .Y(c_s[14]));
        nand2 u_c15 (.A(a_s),     .B(c_s[14]), .Y(c_s[15]));
        nand2 u_c16 (.A(b_s),     .B(c_s[14]), .Y(c_s[16]));
        nand2 u_c17 (.A(c_s[15]), .B(c_s[16]), .Y(c_s[17]));
        nand2 u_c18 (.A(c_s[17]), .B(c_s[17]), .Y(c_s[18]));

        assign not_s[i]  = c_s[0];
        assign and_s[i]  = c_s[2];
        assign or_s[i]   = c_s[5];
        assign nor_s[i]  = c_s[9];
        assign xor_s[i]  = c_s[13];
        assign xnor_s[i] = c_s[18];
    end

`ifdef LOGIC_GATES_USING_NAND_REG_OUT_EN
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] not_r;
    logic [WIDTH-1:0] nor_r;
    logic [WIDTH-1:0] xor_r;
    logic [WIDTH-1:0] xnor_r;

    // Output register stage: async reset to the A=B=0 results, else capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_r  <= {WIDTH{LGN_RST_AND}};
            or_r   <= {WIDTH{LGN_RST_OR}};
            not_r  <= {WIDTH{LGN_RST_NOT}};
            nor_r  <= {WIDTH{LGN_RST_NOR}};
            xor_r  <= {WIDTH{LGN_RST_XOR}};
            xnor_r <= {WIDTH{LGN_RST_XNOR}};
        end else begin
            and_r  <= and_s;
            or_r   <= or_s;
            not_r  <= not_s;
            nor_r  <= nor_s;
            xor_r  <= xor_s;
            xnor_r <= xnor_s;
        end
    end

    assign bus.and_out  = and_r;
    assign bus.or_out   = or_r;
    assign bus.not_out  = not_r;
    assign bus.nor_out  = nor_r;
    assign bus.xor_out  = xor_r;
    assign bus.xnor_out = xnor_r;
`else
    // Clock and reset have no function without the register stage.
    logic unused_s;
    assign unused_s = &{1'b0, clk, rst_n};

    assign bus.and_out  = and_s;
    assign bus.or_out   = or_s;
    assign bus.not_out  = not_s;
    assign bus.nor_out  = nor_s;
    assign bus.xor_out  = xor_s;
    assign bus.xnor_out = xnor_s;
`endif

endmodule

// File: tb/tb_logic_gates_using_nand.sv
// ---------------------------------------------------------------------------
// tb_logic_gates_using_nand
// Directed-vector bench for logic_gates_using_nand at WIDTH=1 and WIDTH=4.
// Works with LOGIC_GATES_USING_NAND_REG_OUT_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_logic_gates_using_nand;
    import lgn_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic_gates_using_nand_if #(.WIDTH(1)) bus1 ();
    logic_gates_using_nand_if #(.WIDTH(4)) bus4 ();

    logic_gates_using_nand #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    logic_gates_using_nand #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Result packing order: {and, or, not, nor, xor, xnor}
    logic [5:0]  obs1;
    logic [23:0] obs4;
    assign obs1 = {bus1.and_out, bus1.or_out, bus1.not_out,
                   bus1.nor_out, bus1.xor_out, bus1.xnor_out};
    assign obs4 = {bus4.and_out, bus4.or_out, bus4.not_out,
                   bus4.nor_out, bus4.xor_out, bus4.xnor_out};

    // Directed table: hand-computed expected results.
    logic [0:0]  tab_a1 [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [0:0]  tab_b1 [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [5:0]  tab_e1 [6] = '{6'b001101, 6'b011010, 6'b010010,
                                6'b110001, 6'b010010, 6'b001101};
    logic [3:0]  tab_a4 [6] = '{4'b0000, 4'b1100, 4'b0101,
                                4'b1111, 4'b1010, 4'b0011};
    logic [3:0]  tab_b4 [6] = '{4'b0000, 4'b1010, 4'b0011,
                                4'b1111, 4'b0101, 4'b1100};
    logic [23:0] tab_e4 [6] = '{24'h00FF0F, 24'h8E3169, 24'h17A869,
                                24'hFF000F, 24'h0F50F0, 24'h0FC0F0};

    localparam logic [5:0]  RST1 = 6'b001101;
    localparam logic [23:0] RST4 = 24'h00FF0F;

    logic [5:0]  prev1 = 6'd0;
    logic [23:0] prev4 = 24'd0;
    logic [17:0] low4;

    task automatic check1(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check4(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Let a new input reach the outputs.
    task automatic settle();
`ifdef LOGIC_GATES_USING_NAND_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #10;
`endif
    endtask

    initial begin
        bus1.A = 1'b0; bus1.B = 1'b0;
        bus4.A = 4'h0; bus4.B = 4'h0;
        $display("nand cells per lane: %0d", LGN_CELLS_PER_LANE);

`ifdef LOGIC_GATES_USING_NAND_REG_OUT_EN
        // Reset with A=B=1 and no clk edge yet: reset values must show.
        bus1.A = 1'b1; bus1.B = 1'b1;
        bus4.A = 4'hF; bus4.B = 4'hF;
        #2;
        check1("rst_no_edge_w1", obs1, RST1);
        check4("rst_no_edge_w4", obs4, RST4);
        #5;                 // past the t=5 edge, still in reset
        check1("rst_hold_w1", obs1, RST1);
        check4("rst_hold_w4", obs4, RST4);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("release_w1", obs1, 6'b110001);
        check4("release_w4", obs4, 24'hFF000F);
        prev1 = 6'b110001;
        prev4 = 24'hFF000F;
`else
        rst_n = 1'b1;
`endif

        for (int i = 0; i < 6; i++) begin
            bus1.A = tab_a1[i]; bus1.B = tab_b1[i];
            bus4.A = tab_a4[i]; bus4.B = tab_b4[i];
`ifdef LOGIC_GATES_USING_NAND_REG_OUT_EN
            #1;
            check1($sformatf("hold_w1_%0d", i), obs1, prev1);
            check4($sformatf("hold_w4_%0d", i), obs4, prev4);
`endif
            settle();
            check1($sformatf("vec_w1_%0d", i), obs1, tab_e1[i]);
            check4($sformatf("vec_w4_%0d", i), obs4, tab_e4[i]);
            prev1 = tab_e1[i];
            prev4 = tab_e4[i];
        end

`ifdef LOGIC_GATES_USING_NAND_REG_OUT_EN
        // Reset pulse between edges: immediate return to reset values.
        #2;
        rst_n = 1'b0;
        #1;
        check1("midrst_w1", obs1, RST1);
        check4("midrst_w4", obs4, RST4);
        @(posedge clk);
        #1;
        check1("midrst_edge_w1", obs1, RST1);
        check4("midrst_edge_w4", obs4, RST4);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("midrst_rel_w1", obs1, tab_e1[5]);
        check4("midrst_rel_w4", obs4, tab_e4[5]);
`endif

        // Unknown on lane 3 only: lanes 2..0 must stay clean.
        bus4.A = 4'bx100;
        bus4.B = 4'b1010;
        settle();
        low4 = {bus4.and_out[2:0], bus4.or_out[2:0], bus4.not_out[2:0],
                bus4.nor_out[2:0], bus4.xor_out[2:0], bus4.xnor_out[2:0]};
        vectors++;
        assert (low4 === 18'b000_110_011_001_110_001) else begin
            miscompares++;
            $error("FAIL x_lane_isolation observed=%b expected=%b",
                   low4, 18'b000_110_011_001_110_001);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
